// File: rtl/fetch_pc_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// instruction width, PC increment and the NOP used as the reset instruction.
package fetch_pc_stage_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_stage_skid.sv
// Single-entry {pc, instr} holding register. It catches a memory response
// that lands while decode is stalled, so the word is never lost.
module fetch_skid_buf
    import fetch_pc_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_load,
    input  logic [ADDR_W-1:0]  i_pc,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic               i_unload,
    input  logic               i_clear,
    output logic               o_valid,
    output logic [ADDR_W-1:0]  o_pc,
    output logic [INSTR_W-1:0] o_instr
);

    logic               r_valid;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;

    // Occupancy flag: clear wins over load, load wins over unload.
    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end else if (i_unload) begin
            r_valid <= 1'b0;
        end
    end

    // Payload capture.
    // NOTE: the payload has no reset; it is only ever read while r_valid is set,
    // so resetting it would add reset fan-out for no functional benefit.
    always_ff @(posedge clock) begin
        if (i_load) begin
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

// File: rtl/fetch_pc_stage.sv
// Instruction-fetch stage: owns the PC, issues word fetches over a req/ack
// handshake, presents {pc, pc+4, instr} to decode under stall control and
// applies branch/jump redirects, dropping any in-flight fetch.
// Optional build macro FETCH_ALIGN_CHECK_EN: misaligned redirect targets are
// not fetched; the stage parks with fetch_misalign set until an aligned
// redirect or reset. Without it, target[1:0] is forced to zero.
module fetch_pc_stage
    import fetch_pc_stage_pkg::*;
#(
    parameter int               ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    input  logic               stall,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_plus4,
    output logic [INSTR_W-1:0] if_instr,
    output logic               fetch_misalign
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    fetch_state_e       r_state;
    fetch_state_e       w_state_next;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_next;
    logic [ADDR_W-1:0]  r_drop_addr;
    logic               r_if_valid;
    logic [ADDR_W-1:0]  r_if_pc;
    logic [ADDR_W-1:0]  r_if_pc_plus4;
    logic [INSTR_W-1:0] r_if_instr;

    logic               w_req_state;
    logic               w_out_free;
    logic               w_consume;
    logic               w_out_clear;
    logic               w_out_load_mem;
    logic               w_out_load_skid;
    logic               w_skid_load;
    logic               w_skid_unload;
    logic               w_skid_clear;
    logic               w_skid_valid;
    logic [ADDR_W-1:0]  w_skid_pc;
    logic [INSTR_W-1:0] w_skid_instr;
    logic               w_parked;

`ifdef FETCH_ALIGN_CHECK_EN
    logic               r_misalign;
    logic               w_misalign_next;
    assign w_parked       = r_misalign;
    assign fetch_misalign = r_misalign;
`else
    assign w_parked       = 1'b0;
    assign fetch_misalign = 1'b0;
`endif

    // A request is outstanding in FETCH and DROP; reset masks it immediately.
    assign w_req_state = (r_state == FETCH) || (r_state == DROP);
    assign imem_req    = w_req_state && !reset;
    assign imem_addr   = (r_state == DROP) ? r_drop_addr : r_pc;

    assign w_consume  = r_if_valid && !stall;
    assign w_out_free = !r_if_valid || !stall;

    // Next-state, next-PC and datapath steering; redirect overrides everything.
    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_out_clear     = 1'b0;
        w_out_load_mem  = 1'b0;
        w_out_load_skid = 1'b0;
        w_skid_load     = 1'b0;
        w_skid_unload   = 1'b0;
        w_skid_clear    = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        w_misalign_next = r_misalign;
`endif
        if (redirect_valid) begin
            w_out_clear  = 1'b1;
            w_skid_clear = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
            if (redirect_target[1:0] != 2'b00) begin
                w_misalign_next = 1'b1;
                w_state_next    = (w_req_state && !imem_ack) ? DROP : HOLD;
            end else begin
                w_misalign_next = 1'b0;
                w_pc_next       = redirect_target;
                w_state_next    = (w_req_state && !imem_ack) ? DROP : FETCH;
            end
`else
            w_pc_next    = {redirect_target[ADDR_W-1:2], 2'b00};
            w_state_next = (w_req_state && !imem_ack) ? DROP : FETCH;
`endif
        end else begin
            unique case (r_state)
                FETCH: begin
                    if (imem_ack) begin
                        w_pc_next = r_pc + STEP;
                        if (w_out_free) begin
                            w_out_load_mem = 1'b1;
                        end else begin
                            w_skid_load  = 1'b1;
                            w_state_next = HOLD;
                        end
                    end else if (w_consume) begin
                        w_out_clear = 1'b1;
                    end
                end
                HOLD: begin
                    if (w_skid_valid && !stall) begin
                        w_out_load_skid = 1'b1;
                        w_skid_unload   = 1'b1;
                        w_state_next    = FETCH;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        w_state_next = w_parked ? HOLD : FETCH;
                    end
                end
                default: w_state_next = FETCH;
            endcase
        end
    end

    // FSM, PC and decode-facing output registers.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= FETCH;
            r_pc          <= RESET_PC;
            r_if_valid    <= 1'b0;
            r_if_pc       <= '0;
            r_if_pc_plus4 <= '0;
            r_if_instr    <= NOP_INSTR;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_out_clear) begin
                r_if_valid <= 1'b0;
            end else if (w_out_load_mem) begin
                r_if_valid    <= 1'b1;
                r_if_pc       <= r_pc;
                r_if_pc_plus4 <= r_pc + STEP;
                r_if_instr    <= imem_rdata;
            end else if (w_out_load_skid) begin
                r_if_valid    <= 1'b1;
                r_if_pc       <= w_skid_pc;
                r_if_pc_plus4 <= w_skid_pc + STEP;
                r_if_instr    <= w_skid_instr;
            end
        end
    end

    // Remember the address of the fetch being dropped so it stays stable.
    always_ff @(posedge clock) begin
        if (r_state == FETCH && redirect_valid) begin
            r_drop_addr <= r_pc;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Sticky misalignment flag, cleared by reset or an aligned redirect.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign_next;
        end
    end
`endif

    fetch_skid_buf #(
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_pc    (r_pc),
        .i_instr (imem_rdata),
        .i_unload(w_skid_unload),
        .i_clear (w_skid_clear),
        .o_valid (w_skid_valid),
        .o_pc    (w_skid_pc),
        .o_instr (w_skid_instr)
    );

    assign if_valid    = r_if_valid;
    assign if_pc       = r_if_pc;
    assign if_pc_plus4 = r_if_pc_plus4;
    assign if_instr    = r_if_instr;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Directed bench for fetch_pc_stage. The memory model returns ~addr as the
// instruction and acks after a programmable number of wait cycles. A second
// instance with RESET_PC=FFFF_FFF8 runs free against a zero-wait memory.
module tb_fetch_pc_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        stall;
    logic        if_valid, fetch_misalign;
    logic [31:0] if_pc, if_pc_plus4, if_instr;

    logic        req2, valid2, mis2;
    logic [31:0] addr2, pc2, pc2_p4, instr2;

    int n_pass  = 0;
    int n_total = 0;
    int n_waits = 0;
    int wait_cnt;

    always #5 clock = ~clock;

    // Wait-state memory model: ack once the request has waited n_waits cycles.
    always @(posedge clock) begin
        if (!imem_req || imem_ack) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end
    assign imem_ack   = imem_req && (wait_cnt == n_waits);
    assign imem_rdata = ~imem_addr;

    fetch_pc_stage dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target), .stall(stall),
        .if_valid(if_valid), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_instr(if_instr),
        .fetch_misalign(fetch_misalign)
    );

    fetch_pc_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clock(clock), .reset(reset),
        .imem_req(req2), .imem_addr(addr2), .imem_ack(req2), .imem_rdata(~addr2),
        .redirect_valid(1'b0), .redirect_target(32'h0), .stall(1'b0),
        .if_valid(valid2), .if_pc(pc2), .if_pc_plus4(pc2_p4), .if_instr(instr2),
        .fetch_misalign(mis2)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        n_waits = 0;
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        step(); step();
        n_total++; if ({if_valid, imem_req, fetch_misalign} !== 3'b000) $display("FAIL reset_flags: got %b exp 000", {if_valid, imem_req, fetch_misalign}); else n_pass++;
        n_total++; if ({if_pc, if_pc_plus4, if_instr} !== 96'h0) $display("FAIL reset_regs: got %h exp 0", {if_pc, if_pc_plus4, if_instr}); else n_pass++;
        reset = 1'b0;
        #1;
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL first_req: got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            step();
            n_total++;
            if (if_valid !== 1'b1 || if_pc !== 32'(i * 4) || if_pc_plus4 !== 32'(i * 4 + 4) || if_instr !== ~32'(i * 4))
                $display("FAIL zero_wait_%0d: got v=%b pc=%h p4=%h ins=%h exp v=1 pc=%h", i, if_valid, if_pc, if_pc_plus4, if_instr, 32'(i * 4));
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        n_waits = 0;
        do_reset();
        step(); step();
        stall = 1'b1;
        n_total++; if (if_pc !== 32'h4 || imem_req !== 1'b1 || imem_addr !== 32'h8) $display("FAIL stall_start: got pc=%h req=%b addr=%h exp pc=4 req=1 addr=8", if_pc, imem_req, imem_addr); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++;
            if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== ~32'h4 || imem_req !== 1'b0)
                $display("FAIL stall_hold_%0d: got v=%b pc=%h req=%b exp v=1 pc=4 req=0", i, if_valid, if_pc, imem_req);
            else n_pass++;
        end
        stall = 1'b0;
        step();
        n_total++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== ~32'h8 || if_pc_plus4 !== 32'hC) $display("FAIL skid_out: got v=%b pc=%h ins=%h exp pc=8", if_valid, if_pc, if_instr); else n_pass++;
        step();
        n_total++; if (if_valid !== 1'b1 || if_pc !== 32'hC) $display("FAIL resume: got v=%b pc=%h exp v=1 pc=c", if_valid, if_pc); else n_pass++;
    endtask

    task automatic test_redirect_wait();
        logic found;
        n_waits = 2;
        do_reset();
        redirect_valid = 1'b1; redirect_target = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || imem_ack !== 1'b0) $display("FAIL drop_addr: got req=%b addr=%h ack=%b exp 1/0/0", imem_req, imem_addr, imem_ack); else n_pass++;
        step();
        n_total++; if (imem_ack !== 1'b1 || imem_addr !== 32'h0) $display("FAIL drop_ack: got ack=%b addr=%h exp ack=1 addr=0", imem_ack, imem_addr); else n_pass++;
        step();
        n_total++; if (if_valid !== 1'b0 || imem_addr !== 32'h100) $display("FAIL drop_discard: got v=%b addr=%h exp v=0 addr=100", if_valid, imem_addr); else n_pass++;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (if_valid) found = 1'b1;
        end
        n_total++; if (!found || if_pc !== 32'h100 || if_instr !== ~32'h100) $display("FAIL redirect_target: got found=%b pc=%h exp pc=100", found, if_pc); else n_pass++;
    endtask

    task automatic test_redirect_ack();
        n_waits = 0;
        do_reset();
        step();
        redirect_valid = 1'b1; redirect_target = 32'h0000_0200;
        n_total++; if (imem_ack !== 1'b1 || imem_addr !== 32'h4) $display("FAIL redir_ack_setup: got ack=%b addr=%h exp 1/4", imem_ack, imem_addr); else n_pass++;
        step();
        redirect_valid = 1'b0;
        n_total++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) $display("FAIL redir_ack_next: got v=%b req=%b addr=%h exp 0/1/200", if_valid, imem_req, imem_addr); else n_pass++;
        step();
        n_total++; if (if_valid !== 1'b1 || if_pc !== 32'h200) $display("FAIL redir_ack_out: got v=%b pc=%h exp 1/200", if_valid, if_pc); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'hFFFF_FFF8 + 32'(i * 4);
            step();
            n_total++;
            if (valid2 !== 1'b1 || pc2 !== exp_pc || pc2_p4 !== exp_pc + 32'h4 || instr2 !== ~exp_pc)
                $display("FAIL wrap_%0d: got v=%b pc=%h p4=%h exp pc=%h", i, valid2, pc2, pc2_p4, exp_pc);
            else n_pass++;
        end
    endtask

    task automatic test_reset_in_drop();
        n_waits = 2;
        do_reset();
        redirect_valid = 1'b1; redirect_target = 32'h0000_0040;
        step();
        redirect_valid = 1'b0;
        reset = 1'b1;
        step();
        n_total++; if (if_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0) $display("FAIL drop_reset: got v=%b req=%b addr=%h exp 0/0/0", if_valid, imem_req, imem_addr); else n_pass++;
        reset = 1'b0;
        n_waits = 0;
        #1;
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL drop_reset_req: got req=%b addr=%h exp 1/0", imem_req, imem_addr); else n_pass++;
        redirect_valid = 1'b1; redirect_target = 32'h0000_0102;
        step();
        redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 2; i++) begin
            n_total++; if (fetch_misalign !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0) $display("FAIL misalign_park_%0d: got mis=%b req=%b v=%b exp 1/0/0", i, fetch_misalign, imem_req, if_valid); else n_pass++;
            step();
        end
        redirect_valid = 1'b1; redirect_target = 32'h0000_0300;
        step();
        redirect_valid = 1'b0;
        n_total++; if (fetch_misalign !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) $display("FAIL misalign_clear: got mis=%b req=%b addr=%h exp 0/1/300", fetch_misalign, imem_req, imem_addr); else n_pass++;
`else
        n_total++; if (fetch_misalign !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) $display("FAIL align_force: got mis=%b req=%b addr=%h exp 0/1/100", fetch_misalign, imem_req, imem_addr); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect_wait();
        test_redirect_ack();
        test_wrap();
        test_reset_in_drop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_pc_stage.md
Name: fetch_pc_stage

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Owns the program counter and issues word fetches to instruction memory over a req/ack handshake.
- Presents {pc, pc+4, instruction} to decode under stall control.
- Applies branch/jump redirects with flush of any in-flight fetch.
- Contains a one-entry skid buffer, so a memory response that arrives during a decode stall is never lost.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC/address width; instruction width is fixed at 32.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request; held high until imem_ack.
- imem_addr  output  ADDR_W  fetch address; stable while imem_req high.
- imem_ack  input  1  one-cycle response strobe; may assert in the same cycle imem_req first goes high (zero-wait memory).
- imem_rdata  input  32  instruction word; valid only with imem_ack.
- redirect_valid  input  1  one-cycle branch/jump taken pulse.
- redirect_target  input  ADDR_W  new PC; sampled with redirect_valid.
- stall  input  1  decode cannot accept; holds the output.
- if_valid  output  1  output registers hold an unconsumed instruction.
- if_pc  output  ADDR_W  PC of if_instr.
- if_pc_plus4  output  ADDR_W  if_pc + 4, mod 2^ADDR_W.
- if_instr  output  32  fetched instruction.
- fetch_misalign  output  1  see Optional Feature.

Behaviour:
- Reset (clock edge with reset=1):
  - pc=RESET_PC, state=FETCH, skid empty.
  - Outputs: if_valid=0, if_pc=0, if_pc_plus4=0, if_instr=0, imem_req=0, fetch_misalign=0.
  - First request (imem_addr=RESET_PC) issues on the first cycle after reset deasserts.
  - Reset mid-operation discards everything in one cycle; the memory is reset by the same signal.
- Consume rule: decode takes the output on any cycle with if_valid=1 and stall=0.
- States:
  - FETCH:
    - imem_req=1, imem_addr=pc.
    - On imem_ack, output free (if_valid=0 or stall=0): load if_instr=imem_rdata, if_pc=pc, if_pc_plus4=pc+4; set if_valid=1; pc<=pc+4; stay in FETCH.
    - On imem_ack, output occupied (if_valid=1 and stall=1): write the response into the skid (instr, pc); pc<=pc+4; go to HOLD.
    - No imem_ack and the output was consumed: if_valid<=0.
  - HOLD:
    - imem_req=0.
    - When stall=0: output<=skid, skid empty, if_valid stays 1, go to FETCH.
  - DROP:
    - Entered when a redirect arrives with a request outstanding and no ack in that cycle.
    - imem_req stays 1 with the old imem_addr until imem_ack; that data is discarded; then go to FETCH at pc.
- Throughput and latency:
  - Zero-wait memory: 1 instruction/cycle.
  - Fetch latency: req-to-if_valid is 1 cycle after imem_ack.
- Redirect (highest priority below reset; ignores stall):
  - pc<=redirect_target; if_valid<=0; skid cleared.
  - A response acked in the redirect cycle is discarded.
  - Next state is FETCH if no request is outstanding, else DROP.
  - A redirect during DROP updates pc only (last target wins).
- Wrap: pc 32'hFFFF_FFFC + 4 = 32'h0000_0000; if_pc_plus4 wraps the same way.
- imem_addr[1:0] is always 2'b00 unless misaligned per the Optional Feature.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined: a redirect_target with [1:0]!=0 is not fetched.
  - fetch_misalign<=1 and state parks in HOLD with imem_req=0 and if_valid=0.
  - It stays there until the next valid (aligned) redirect or reset, which clears fetch_misalign.
- Undefined:
  - fetch_misalign is tied to 0.
  - redirect_target[1:0] is forced to 2'b00 when loaded into pc.

Decomposition:
- Shared package holds:
  - State encoding: FETCH=2'd0, HOLD=2'd1, DROP=2'd2.
  - INSTR_W=32.
  - PC_STEP=4.
  - NOP instruction constant 32'h0000_0000, used as the if_instr reset value.
- One natural sub-module: fetch_skid_buf, a single-entry {pc, instr} holding register with load, unload and clear.
- The FSM and PC logic remain in the top.

Test Plan:
- Reset + zero-wait memory (ack same cycle as req), stall=0:
  - if_pc=0,4,8,12 on consecutive cycles after reset release.
  - if_pc_plus4 = if_pc+4; if_instr equals the memory word.
- Stall=1 for 3 cycles while if_valid=1, ack arriving in stall cycle 1:
  - Outputs hold.
  - imem_req=0 from the next cycle.
  - After release, the skid instruction (pc+4) appears with no gap, then fetch resumes at pc+8.
- 2-wait-state memory, redirect_valid with target 32'h0000_0100 in cycle 1 of the wait:
  - imem_addr stays at the old address until ack; the data is dropped.
  - The next if_valid shows if_pc=32'h100.
- Redirect in the same cycle as imem_ack:
  - The acked word is never presented.
  - if_valid=0 in the next cycle; the following request addresses the target.
- RESET_PC=32'hFFFF_FFF8, free run: if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset asserted mid-DROP:
  - Next cycle: if_valid=0, imem_req=0, pc=RESET_PC.
  - With FETCH_ALIGN_CHECK_EN, a redirect to 32'h102 gives fetch_misalign=1 and imem_req=0 until an aligned redirect.
